// File: rtl/usb3_wr_arbiter.sv
// Write-side scheduler for the FX3 GPIF-II slave FIFO: two stream channels share
// the 32-bit write port, with whole bursts granted round-robin.
module usb3_wr_arbiter #(
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned ADDR_LAT  = 3,
  parameter int unsigned GAP       = 2,
  parameter logic [1:0]  TH0_ADDR  = 2'b00,
  parameter logic [1:0]  TH1_ADDR  = 2'b01
) (
  input  logic        clk125m,
  input  logic        rst,
  input  logic        ch0_valid,
  input  logic [31:0] ch0_data,
  input  logic        ch0_last,
  output logic        ch0_ready,
  input  logic        ch1_valid,
  input  logic [31:0] ch1_data,
  input  logic        ch1_last,
  output logic        ch1_ready,
  input  logic        flaga,
  input  logic        flagb,
  input  logic        flagc,
  input  logic        flagd,
  output logic        slcs_n,
  output logic        slwr_n,
  output logic        slrd_n,
  output logic        sloe_n,
  output logic        pktend_n,
  output logic [1:0]  a,
  output logic [31:0] data,
  output logic        grant,
  output logic        busy
);

  localparam int unsigned CNT_W   = $clog2(BURST_LEN + 1);
  localparam int unsigned TMR_MAX = (ADDR_LAT > GAP) ? ADDR_LAT : GAP;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] LAT_END   = TMR_W'(ADDR_LAT - 1);
  localparam logic [TMR_W-1:0] GAP_END   = TMR_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CHECK,
    S_BURST,
    S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [TMR_W-1:0] tmr;
  logic             prio;

  logic             sel_valid;
  logic [31:0]      sel_data;
  logic             sel_last;
  logic             sel_flag;
  logic             in_burst;
  logic             accept;
  logic             pick;
  logic [CNT_W-1:0] word_nxt;

  // FX3 flags C/D are not used by this write path.
  logic unused_flags;
  assign unused_flags = flagc | flagd;

  always_comb begin
    sel_valid = grant ? ch1_valid : ch0_valid;
    sel_data  = grant ? ch1_data  : ch0_data;
    sel_last  = grant ? ch1_last  : ch0_last;
    sel_flag  = grant ? flagb     : flaga;
    in_burst  = (state == S_BURST) && (word_cnt < BURST_MAX);
    accept    = sel_valid && in_burst;
    word_nxt  = word_cnt + CNT_W'(1);
    // Contention goes to prio; otherwise whichever channel is requesting.
    pick      = (ch0_valid && ch1_valid) ? prio : ch1_valid;
  end

  assign ch0_ready = in_burst && !grant;
  assign ch1_ready = in_burst && grant;

  // Read path is never used by this block.
  assign slrd_n = 1'b1;
  assign sloe_n = 1'b1;

  always_ff @(posedge clk125m) begin
    // NOTE: non-blocking assignments keep every register update in this block
    // based on pre-edge values, so statement order cannot create races.
    if (rst) begin
      state    <= S_IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      a        <= TH0_ADDR;
      data     <= '0;
      slcs_n   <= 1'b1;
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;
      busy     <= 1'b0;
      word_cnt <= '0;
      tmr      <= '0;
    end else begin
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ch0_valid || ch1_valid) begin
            grant  <= pick;
            a      <= pick ? TH1_ADDR : TH0_ADDR;
            tmr    <= '0;
            slcs_n <= 1'b0;
            busy   <= 1'b1;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (tmr == LAT_END) state <= S_CHECK;
          else                tmr   <= tmr + TMR_W'(1);
        end
        S_CHECK: begin
          tmr      <= '0;
          word_cnt <= '0;
          state    <= sel_flag ? S_BURST : S_GAP;
        end
        S_BURST: begin
          if (accept) begin
            slwr_n   <= 1'b0;
            data     <= sel_data;
            word_cnt <= word_nxt;
            // A full packet commits by itself; only a short one needs PKTEND.
            if (sel_last && (word_nxt != BURST_MAX)) pktend_n <= 1'b0;
            if (sel_last || (word_nxt == BURST_MAX)) state <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr == GAP_END) begin
            prio   <= ~grant;
            slcs_n <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_wr_arbiter.sv
// Bench for usb3_wr_arbiter: directed scenarios plus randomized traffic, checked
// against a packet-level scoreboard of accepted words per channel.
module tb_usb3_wr_arbiter;

  localparam int BURST_LEN = 256;
  localparam int ADDR_LAT  = 3;
  localparam int GAP       = 2;
  localparam logic [1:0] TH0 = 2'b00;
  localparam logic [1:0] TH1 = 2'b01;
  localparam int FIRST_WR  = 1 + ADDR_LAT + 1 + 1;
  localparam int FAIL_PATH = 1 + ADDR_LAT + 1 + GAP;
  localparam int PERIOD    = 1 + ADDR_LAT + 1 + BURST_LEN + GAP;
  localparam int MIN_SPACE = GAP + 1 + ADDR_LAT + 1 + 1;

  logic        clk125m = 1'b0;
  logic        rst;
  logic        ch0_valid, ch0_last, ch0_ready;
  logic        ch1_valid, ch1_last, ch1_ready;
  logic [31:0] ch0_data, ch1_data;
  logic        flaga, flagb, flagc, flagd;
  logic        slcs_n, slwr_n, slrd_n, sloe_n, pktend_n;
  logic [1:0]  a;
  logic [31:0] data;
  logic        grant, busy;

  always #4 clk125m = ~clk125m;

  usb3_wr_arbiter #(
    .BURST_LEN(BURST_LEN), .ADDR_LAT(ADDR_LAT), .GAP(GAP),
    .TH0_ADDR(TH0), .TH1_ADDR(TH1)
  ) dut (
    .clk125m(clk125m), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_last(ch0_last), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_last(ch1_last), .ch1_ready(ch1_ready),
    .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd),
    .slcs_n(slcs_n), .slwr_n(slwr_n), .slrd_n(slrd_n), .sloe_n(sloe_n), .pktend_n(pktend_n),
    .a(a), .data(data), .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    t0;

  // Scoreboard: words accepted per channel, plus a log of the packets seen on the pins.
  word_t q0[$];
  word_t q1[$];
  int    wr_in_burst, wr_total, pktend_cnt, last_wr_cyc;
  logic [1:0] cur_a;
  int    burst_start[$];
  int    burst_len[$];
  int    burst_ch[$];

  // Channel sources: mode 0 continuous, 1 random valid, 2 two-on/three-off.
  logic        src_en      [2];
  int          src_mode    [2];
  logic [31:0] src_word    [2];
  int          src_left    [2];
  logic [31:0] src_last_at [2];
  logic        src_rand    [2];
  logic        src_last    [2];
  int          src_phase   [2];
  logic        acc         [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  function automatic logic pick_last(input int c);
    return ((src_last_at[c] != 32'd0) && (src_word[c] == src_last_at[c])) ||
           (src_rand[c] && ($urandom_range(0, 63) == 0));
  endfunction

  task automatic src_cfg(input int c, input logic en, input int mode, input logic [31:0] first,
                         input int left, input logic [31:0] last_at, input logic rnd);
    src_en[c]      = en;
    src_mode[c]    = mode;
    src_word[c]    = first;
    src_left[c]    = left;
    src_last_at[c] = last_at;
    src_rand[c]    = rnd;
    src_phase[c]   = 0;
    acc[c]         = 1'b0;
    src_last[c]    = pick_last(c);
  endtask

  task automatic src_drive();
    logic v [2];
    for (int c = 0; c < 2; c++) begin
      case (src_mode[c])
        1:       v[c] = ($urandom_range(0, 3) != 0);
        2:       v[c] = ((src_phase[c] % 5) < 2);
        default: v[c] = 1'b1;
      endcase
      v[c] = v[c] && src_en[c] && (src_left[c] > 0);
    end
    ch0_valid = v[0]; ch0_data = src_word[0]; ch0_last = src_last[0];
    ch1_valid = v[1]; ch1_data = src_word[1]; ch1_last = src_last[1];
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete();
    burst_start.delete(); burst_len.delete(); burst_ch.delete();
    wr_in_burst = 0; wr_total = 0; pktend_cnt = 0; last_wr_cyc = 0; cur_a = TH0;
  endtask

  // Every write on the pins must be the oldest accepted word of the addressed
  // channel; PKTEND only on a short packet's final word.
  task automatic monitor();
    word_t w;
    logic  exp_pk, is_ch1;
    check1("slrd_n_high", slrd_n, 1'b1);
    check1("sloe_n_high", sloe_n, 1'b1);
    if (slwr_n === 1'b0) begin
      is_ch1 = (a == TH1);
      check1("wr_thread_addr", (a == TH0) || is_ch1, 1'b1);
      check1("wr_grant", grant, is_ch1);
      if (wr_in_burst == 0) begin
        if (burst_start.size() > 0)
          check1("burst_spacing", (cyc - last_wr_cyc) >= MIN_SPACE, 1'b1);
        burst_start.push_back(cyc);
        burst_ch.push_back(is_ch1 ? 1 : 0);
        cur_a = a;
      end else begin
        check("wr_addr_stable", {30'b0, a}, {30'b0, cur_a});
      end
      check1("wr_has_word", is_ch1 ? (q1.size() > 0) : (q0.size() > 0), 1'b1);
      w = '0;
      if (is_ch1 && q1.size() > 0)       w = q1.pop_front();
      else if (!is_ch1 && q0.size() > 0) w = q0.pop_front();
      check("wr_data", data, w.data);
      wr_in_burst++;
      exp_pk = !(w.last && (wr_in_burst < BURST_LEN));
      check1("wr_pktend", pktend_n, exp_pk);
      if (pktend_n === 1'b0) pktend_cnt++;
      wr_total++;
      last_wr_cyc = cyc;
      if (w.last || wr_in_burst == BURST_LEN) begin
        burst_len.push_back(wr_in_burst);
        wr_in_burst = 0;
      end
    end else begin
      check1("pktend_without_wr", pktend_n, 1'b1);
    end
  endtask

  task automatic cycle();
    @(negedge clk125m);
    monitor();
    acc[0] = ch0_valid && ch0_ready && !rst;
    acc[1] = ch1_valid && ch1_ready && !rst;
    if (acc[0]) q0.push_back(word_t'({ch0_last, ch0_data}));
    if (acc[1]) q1.push_back(word_t'({ch1_last, ch1_data}));
    @(posedge clk125m);
    cyc++;
    #1;
    for (int c = 0; c < 2; c++) begin
      src_phase[c]++;
      if (acc[c]) begin
        src_word[c] = src_word[c] + 32'd1;
        src_left[c]--;
        src_last[c] = pick_last(c);
      end
    end
    src_drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (wr_total < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, 32'(wr_total), 32'(n));
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, "_slcs_n"}, slcs_n, 1'b1);
    check1({tag, "_slwr_n"}, slwr_n, 1'b1);
    check1({tag, "_slrd_n"}, slrd_n, 1'b1);
    check1({tag, "_sloe_n"}, sloe_n, 1'b1);
    check1({tag, "_pktend_n"}, pktend_n, 1'b1);
    check({tag, "_a"}, {30'b0, a}, {30'b0, TH0});
    check({tag, "_data"}, data, 32'd0);
    check1({tag, "_ch0_ready"}, ch0_ready, 1'b0);
    check1({tag, "_ch1_ready"}, ch1_ready, 1'b0);
    check1({tag, "_grant"}, grant, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flaga = 1'b1; flagb = 1'b0; flagc = 1'b0; flagd = 1'b0;
    model_clear();

    // Reset held while ch0 streams, then ch0 words 1..512 in two full bursts.
    src_cfg(0, 1'b1, 0, 32'd1, 512, 32'd0, 1'b0);
    src_cfg(1, 1'b0, 0, 32'd0, 0, 32'd0, 1'b0);
    src_drive();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_reset_vals("rst_hold");
    end
    rst = 1'b0;
    model_clear();
    t0 = cyc;
    run_writes("t2_writes", 512, 1200);
    repeat (10) cycle();
    check("t2_latency", 32'(burst_start[0] - t0), 32'(FIRST_WR));
    check("t2_period", 32'(burst_start[1] - burst_start[0]), 32'(PERIOD));
    check("t2_nbursts", 32'(burst_len.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      check("t2_len", 32'(burst_len[i]), 32'(BURST_LEN));
      check("t2_chan", 32'(burst_ch[i]), 32'd0);
    end
    check("t2_pktend", 32'(pktend_cnt), 32'd0);
    check("t2_drained", 32'(q0.size()), 32'd0);

    // Both channels continuous: grants alternate 0,1,0,1 with full bursts.
    flaga = 1'b1; flagb = 1'b1;
    src_cfg(0, 1'b1, 0, 32'h0000_1001, 512, 32'd0, 1'b0);
    src_cfg(1, 1'b1, 0, 32'h1000_0001, 512, 32'd0, 1'b0);
    do_reset(2);
    run_writes("t3_writes", 1024, 1300);
    for (int i = 0; i < 4; i++) begin
      check("t3_grant_order", 32'(burst_ch[i]), 32'(i % 2));
      check("t3_len", 32'(burst_len[i]), 32'(BURST_LEN));
    end
    check("t3_period", 32'(burst_start[1] - burst_start[0]), 32'(PERIOD));
    check("t3_pktend", 32'(pktend_cnt), 32'd0);

    // ch1 short packet of 10 words ending in last.
    src_cfg(0, 1'b0, 0, 32'd0, 0, 32'd0, 1'b0);
    src_cfg(1, 1'b1, 0, 32'h2000_0001, 10, 32'h2000_000A, 1'b0);
    do_reset(2);
    t0 = cyc;
    run_writes("t4_writes", 10, 100);
    check("t4_latency", 32'(burst_start[0] - t0), 32'(FIRST_WR));
    check("t4_nbursts", 32'(burst_len.size()), 32'd1);
    check("t4_len", 32'(burst_len[0]), 32'd10);
    check("t4_chan", 32'(burst_ch[0]), 32'd1);
    check("t4_pktend_count", 32'(pktend_cnt), 32'd1);
    check1("t4_gap_busy", busy, 1'b1);
    check1("t4_gap_slcs_n", slcs_n, 1'b0);
    cycle();
    check1("t4_idle_busy", busy, 1'b0);
    check1("t4_idle_slcs_n", slcs_n, 1'b1);

    // flaga low: ch0 CHECK fails, ch1 bursts, then ch0 is retried.
    flaga = 1'b0; flagb = 1'b1;
    src_cfg(0, 1'b1, 0, 32'h3000_0001, 256, 32'd0, 1'b0);
    src_cfg(1, 1'b1, 0, 32'h4000_0001, 256, 32'd0, 1'b0);
    do_reset(2);
    t0 = cyc;
    cycle();
    check("t5_first_addr", {30'b0, a}, {30'b0, TH0});
    check1("t5_first_grant", grant, 1'b0);
    check1("t5_busy", busy, 1'b1);
    check1("t5_slcs_n", slcs_n, 1'b0);
    run_writes("t5_first_wr", 1, 60);
    flaga = 1'b1;
    check("t5_latency", 32'(burst_start[0] - t0), 32'(FAIL_PATH + FIRST_WR));
    check("t5_chan0", 32'(burst_ch[0]), 32'd1);
    run_writes("t5_writes", 512, 700);
    check("t5_chan1", 32'(burst_ch[1]), 32'd0);
    check("t5_len0", 32'(burst_len[0]), 32'(BURST_LEN));
    check("t5_len1", 32'(burst_len[1]), 32'(BURST_LEN));

    // ch0 valid 2 on / 3 off, then reset in the middle of the next burst.
    src_cfg(0, 1'b1, 2, 32'h5000_0001, 400, 32'd0, 1'b0);
    src_cfg(1, 1'b0, 0, 32'd0, 0, 32'd0, 1'b0);
    do_reset(2);
    run_writes("t6_writes", BURST_LEN + 20, 1600);
    check("t6_len", 32'(burst_len[0]), 32'(BURST_LEN));
    check("t6_nstarts", 32'(burst_start.size()), 32'd2);
    check("t6_pktend", 32'(pktend_cnt), 32'd0);
    check1("t6_busy_pre", busy, 1'b1);
    rst = 1'b1;
    cycle();
    check_reset_vals("t6_midrst");
    rst = 1'b0;
    model_clear();

    // Randomized valids, lasts and flags on both channels.
    src_cfg(0, 1'b1, 1, 32'h6000_0001, 2000, 32'd0, 1'b1);
    src_cfg(1, 1'b1, 1, 32'h7000_0001, 2000, 32'd0, 1'b1);
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      flaga = ($urandom_range(0, 3) != 0);
      flagb = ($urandom_range(0, 3) != 0);
      flagc = 1'($urandom_range(0, 1));
      flagd = 1'($urandom_range(0, 1));
      cycle();
    end
    src_en[0] = 1'b0;
    src_en[1] = 1'b0;
    flaga = 1'b1; flagb = 1'b1;
    repeat (20) cycle();
    check("t7_q0_drained", 32'(q0.size()), 32'd0);
    check("t7_q1_drained", 32'(q1.size()), 32'd0);
    check1("t7_activity", wr_total > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
